// File: rtl/flappy_pkg.sv
// Shared types and screen geometry for the flappy-bird datapath.
package flappy_pkg;

    typedef enum logic [1:0] {
        READY  = 2'd0,
        FLYING = 2'd1,
        DYING  = 2'd2,
        DEAD   = 2'd3
    } bird_state_t;

    localparam int unsigned SCREEN_H  = 480;
    localparam int unsigned BIRD_SZ   = 15;
    localparam int unsigned Y_MAX_DEF = SCREEN_H - BIRD_SZ;

endpackage

// File: rtl/flap_latch.sv
// Flap button rising-edge detector with a pending bit held until the next frame tick.
module flap_latch (
    input  logic clk,
    input  logic rst,
    input  logic flap,
    input  logic consume,
    input  logic clear,
    output logic pend
);

    logic r_flap_q;
    logic r_pend;
    logic w_edge;

    assign w_edge = flap & ~r_flap_q;
    // An edge arriving in the consuming cycle is seen by that same tick.
    assign pend   = r_pend | w_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flap_q <= 1'b0;
            r_pend   <= 1'b0;
        end else begin
            r_flap_q <= flap;
            if (clear || consume) begin
                r_pend <= 1'b0;
            end else if (w_edge) begin
                r_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bird_motion.sv
// Bird physics: position, signed velocity, gravity, flap impulse, clamps and life-cycle FSM.
module bird_motion
    import flappy_pkg::*;
#(
    parameter int unsigned Y_W     = 16,
    parameter int unsigned V_W     = 8,
    parameter int unsigned Y_START = 240,
    parameter int unsigned Y_MIN   = 0,
    parameter int unsigned Y_MAX   = Y_MAX_DEF,
    parameter int unsigned GRAV    = 1,
    parameter int unsigned JUMP_V  = 7,
    parameter int unsigned V_MAX   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  flap,
    input  logic                  hit,
    input  logic                  restart,
    output logic [Y_W-1:0]        bird_y,
    output logic signed [V_W-1:0] bird_v,
    output logic [1:0]            state,
    output logic                  alive,
    output logic                  game_over
);

    localparam logic signed [V_W:0]   L_GRAV   = (V_W+1)'(GRAV);
    localparam logic signed [V_W:0]   L_VMAX_X = (V_W+1)'(V_MAX);
    localparam logic signed [V_W:0]   L_VMIN_X = {2'b11, {(V_W-1){1'b0}}};
    localparam logic signed [V_W-1:0] L_VMAX   = V_W'(V_MAX);
    localparam logic signed [V_W-1:0] L_VMIN   = {1'b1, {(V_W-1){1'b0}}};
    localparam logic signed [V_W-1:0] L_VJUMP  = V_W'(0 - JUMP_V);
    localparam logic signed [Y_W+1:0] L_YMIN_X = (Y_W+2)'(Y_MIN);
    localparam logic signed [Y_W+1:0] L_YMAX_X = (Y_W+2)'(Y_MAX);
    localparam logic [Y_W-1:0]        L_YSTART = Y_W'(Y_START);
    localparam logic [Y_W-1:0]        L_YMIN   = Y_W'(Y_MIN);
    localparam logic [Y_W-1:0]        L_YMAX   = Y_W'(Y_MAX);

    logic [Y_W-1:0]        r_y,  w_y_d;
    logic signed [V_W-1:0] r_v,  w_v_d;
    bird_state_t           r_st, w_st_d;

    logic                  w_pend;
    logic                  w_consume;
    logic signed [V_W:0]   w_v_sum;
    logic signed [V_W-1:0] w_v_grav;
    logic signed [V_W-1:0] w_v_step;
    logic signed [Y_W+1:0] w_y_sum;
    logic                  w_ceil;
    logic                  w_floor;

    flap_latch u_flap_latch (
        .clk     (clk),
        .rst     (rst),
        .flap    (flap),
        .consume (w_consume),
        .clear   (restart),
        .pend    (w_pend)
    );

    // Gravity step, saturated to the terminal velocity and the signed range.
    assign w_v_sum = $signed({r_v[V_W-1], r_v}) + L_GRAV;
    always_comb begin
        w_v_grav = w_v_sum[V_W-1:0];
        if (w_v_sum > L_VMAX_X) begin
            w_v_grav = L_VMAX;
        end else if (w_v_sum < L_VMIN_X) begin
            w_v_grav = L_VMIN;
        end
    end

    // Position uses the old velocity, widened so ceiling underflow stays negative.
    assign w_y_sum = $signed({2'b00, r_y}) + $signed({{(Y_W+2-V_W){r_v[V_W-1]}}, r_v});
    assign w_ceil  = w_y_sum < L_YMIN_X;
    assign w_floor = w_y_sum >= L_YMAX_X;

    always_comb begin
        w_st_d    = r_st;
        w_y_d     = r_y;
        w_v_d     = r_v;
        w_consume = 1'b0;
        // A hit in the same tick as a flap wins: the impulse is dropped.
        w_v_step  = (r_st == FLYING && w_pend && !hit) ? L_VJUMP : w_v_grav;
        if (tick) begin
            case (r_st)
                READY: begin
                    w_consume = 1'b1;
                    if (w_pend) begin
                        w_v_d  = L_VJUMP;
                        w_st_d = FLYING;
                    end
                end
                FLYING, DYING: begin
                    w_consume = 1'b1;
                    if (w_floor) begin
                        w_y_d  = L_YMAX;
                        w_v_d  = '0;
                        w_st_d = DEAD;
                    end else begin
                        if (w_ceil) begin
                            w_y_d = L_YMIN;
                            w_v_d = w_v_step[V_W-1] ? '0 : w_v_step;
                        end else begin
                            w_y_d = w_y_sum[Y_W-1:0];
                            w_v_d = w_v_step;
                        end
                        if (r_st == FLYING && hit) begin
                            w_st_d = DYING;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_y  <= L_YSTART;
            r_v  <= '0;
            r_st <= READY;
        end else begin
            r_y  <= w_y_d;
            r_v  <= w_v_d;
            r_st <= w_st_d;
        end
    end

    assign bird_y    = r_y;
    assign bird_v    = r_v;
    assign state     = r_st;
    assign alive     = (r_st == READY) || (r_st == FLYING);
    assign game_over = (r_st == DEAD);

endmodule

// File: tb/tb_bird_motion.sv
// Directed bench for bird_motion: vector table for flap handling plus corner-case sequences.
module tb_bird_motion;
    import flappy_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               tick;
    logic               flap;
    logic               hit;
    logic               restart;
    logic [15:0]        bird_y;
    logic signed [7:0]  bird_v;
    logic [1:0]         state;
    logic               alive;
    logic               game_over;

    int n_chk = 0;
    int n_err = 0;
    int m_y;
    int m_v;
    logic [1:0] m_st;

    typedef struct {
        logic [3:0] ctl;   // {tick, flap, hit, restart}
        int         ey;
        int         ev;
        logic [1:0] es;
    } vec_t;

    vec_t vt[20];

    bird_motion dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .flap      (flap),
        .hit       (hit),
        .restart   (restart),
        .bird_y    (bird_y),
        .bird_v    (bird_v),
        .state     (state),
        .alive     (alive),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, want summary before it");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [3:0] ctl, input int ey, input int ev,
                                input logic [1:0] es);
        vec_t v;
        v.ctl = ctl;
        v.ey  = ey;
        v.ev  = ev;
        v.es  = es;
        return v;
    endfunction

    // Inputs change 1 time unit after the edge; outputs are read there too.
    task automatic step(input logic t, input logic f, input logic h, input logic r);
        tick    = t;
        flap    = f;
        hit     = h;
        restart = r;
        @(posedge clk);
        #1;
        tick    = 1'b0;
        hit     = 1'b0;
        restart = 1'b0;
    endtask

    task automatic check(input string nm, input int ey, input int ev, input logic [1:0] es);
        int   ay;
        int   av;
        logic ea;
        logic eg;
        ay = bird_y;
        av = bird_v;
        ea = (es == READY) || (es == FLYING);
        eg = (es == DEAD);
        n_chk++;
        if (ay != ey) begin
            n_err++;
            $display("FAIL %s bird_y: got %0d want %0d", nm, ay, ey);
        end
        n_chk++;
        if (av != ev) begin
            n_err++;
            $display("FAIL %s bird_v: got %0d want %0d", nm, av, ev);
        end
        n_chk++;
        if (state !== es) begin
            n_err++;
            $display("FAIL %s state: got %0d want %0d", nm, state, es);
        end
        n_chk++;
        if (alive !== ea) begin
            n_err++;
            $display("FAIL %s alive: got %b want %b", nm, alive, ea);
        end
        n_chk++;
        if (game_over !== eg) begin
            n_err++;
            $display("FAIL %s game_over: got %b want %b", nm, game_over, eg);
        end
    endtask

    // Downward reference step: gravity capped at 8, floor at 465 ends the flight.
    task automatic model_fall(output logic at_floor);
        int ysum;
        ysum = m_y + m_v;
        at_floor = (ysum >= 465);
        if (at_floor) begin
            m_y  = 465;
            m_v  = 0;
            m_st = DEAD;
        end else begin
            m_y = ysum;
            m_v = (m_v + 1 > 8) ? 8 : m_v + 1;
        end
    endtask

    initial begin
        logic fl;

        vt[0]  = mk(4'b1000, 240,  0, READY);
        vt[1]  = mk(4'b1000, 240,  0, READY);
        vt[2]  = mk(4'b1000, 240,  0, READY);
        vt[3]  = mk(4'b1000, 240,  0, READY);
        vt[4]  = mk(4'b1000, 240,  0, READY);
        vt[5]  = mk(4'b0100, 240,  0, READY);
        vt[6]  = mk(4'b1000, 240, -7, FLYING);
        vt[7]  = mk(4'b1000, 233, -6, FLYING);
        vt[8]  = mk(4'b1000, 227, -5, FLYING);
        vt[9]  = mk(4'b1100, 222, -7, FLYING);
        vt[10] = mk(4'b1100, 215, -6, FLYING);
        vt[11] = mk(4'b0000, 215, -6, FLYING);
        vt[12] = mk(4'b0100, 215, -6, FLYING);
        vt[13] = mk(4'b0000, 215, -6, FLYING);
        vt[14] = mk(4'b0100, 215, -6, FLYING);
        vt[15] = mk(4'b0000, 215, -6, FLYING);
        vt[16] = mk(4'b0100, 215, -6, FLYING);
        vt[17] = mk(4'b0000, 215, -6, FLYING);
        vt[18] = mk(4'b1000, 209, -7, FLYING);
        vt[19] = mk(4'b1000, 202, -6, FLYING);

        rst = 1'b1;
        tick = 1'b0; flap = 1'b0; hit = 1'b0; restart = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("reset", 240, 0, READY);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            step(vt[i].ctl[3], vt[i].ctl[2], vt[i].ctl[1], vt[i].ctl[0]);
            check($sformatf("vec%0d", i), vt[i].ey, vt[i].ev, vt[i].es);
        end

        // Climb with a fresh flap edge every tick until the ceiling clamps.
        for (int k = 1; k <= 29; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            check($sformatf("climb%0d", k), 196 - 7 * (k - 1), -7, FLYING);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("ceiling_clamp", 0, 0, FLYING);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("ceiling_next", 0, 1, FLYING);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("ceiling_leave", 1, 2, FLYING);

        // Free fall to the floor; hit coincides with the floor crossing.
        m_y = 1; m_v = 2; m_st = FLYING;
        for (int k = 0; k < 100 && m_st != DEAD; k++) begin
            model_fall(fl);
            step(1'b1, 1'b0, fl, 1'b0);
            check($sformatf("fall%0d", k), m_y, m_v, m_st);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("dead_hold0", 465, 0, DEAD);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("dead_hold1", 465, 0, DEAD);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("dead_hold2", 465, 0, DEAD);

        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("restart_dead", 240, 0, READY);

        // Hit together with a pending flap: gravity only, DYING.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("launch", 240, -7, FLYING);
        m_y = 240; m_v = -7; m_st = FLYING;
        for (int k = 0; k < 12; k++) begin
            model_fall(fl);
            step(1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("arc%0d", k), m_y, m_v, m_st);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("hit_with_flap", 227, 6, DYING);

        // Flaps during DYING are ignored.
        m_y = 227; m_v = 6; m_st = DYING;
        for (int k = 0; k < 100 && m_st != DEAD; k++) begin
            model_fall(fl);
            step(1'b1, (k % 2 == 0), 1'b0, 1'b0);
            check($sformatf("dying%0d", k), m_y, m_v, m_st);
        end

        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("restart_dead_tick", 240, 0, READY);

        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("fly_again", 233, -6, FLYING);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("restart_flying", 240, 0, READY);

        // Restart drops a pending flap.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("restart_clears_pend", 240, 0, READY);

        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("edge_on_tick", 240, -7, FLYING);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("hit_plain", 227, -5, DYING);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("restart_dying_tick", 240, 0, READY);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("after_restart_tick", 240, 0, READY);

        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("pre_rst", 233, -6, FLYING);
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_midflight", 240, 0, READY);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("post_rst_tick", 240, 0, READY);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
